// File: rtl/toggle_debounce.sv
// Push-button front end: 2-flop synchroniser, stable-count debounce FSM, one-cycle t pulse per press.
// Define AUTO_REPEAT_EN to emit repeat pulses while the button stays held.
module toggle_debounce #(
   parameter int DEBOUNCE_CYCLES = 4,
   parameter int CNT_W           = 16,
   parameter int REPEAT_DELAY    = 8,
   parameter int REPEAT_PERIOD   = 4
) (
   input  logic clk,
   input  logic rst_n,
   input  logic btn_in,
   output logic t,
   output logic level
);

   typedef enum logic [1:0] {
      IDLE        = 2'd0,
      ARM_PRESS   = 2'd1,
      HELD        = 2'd2,
      ARM_RELEASE = 2'd3
   } state_t;

   localparam logic [CNT_W-1:0] LP_ONE     = CNT_W'(1);
   localparam logic [CNT_W-1:0] LP_DB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   generate
      if (DEBOUNCE_CYCLES < 2 || REPEAT_DELAY < 2 || REPEAT_PERIOD < 2 ||
          64'(DEBOUNCE_CYCLES) >= (64'd1 << CNT_W)) begin : g_bad_cfg
         $error("toggle_debounce: illegal parameter combination");
      end
   endgenerate

   state_t           r_state;
   logic             r_s1;
   logic             r_s2;
   logic             r_t;
   logic             r_level;
   logic [CNT_W-1:0] r_cnt;

`ifdef AUTO_REPEAT_EN
   localparam logic [CNT_W-1:0] LP_DELAY_LAST  = CNT_W'(REPEAT_DELAY - 1);
   localparam logic [CNT_W-1:0] LP_PERIOD_LAST = CNT_W'(REPEAT_PERIOD - 1);

   // r_rpt_run distinguishes the initial delay from the steady repeat period
   logic [CNT_W-1:0] r_rpt_cnt;
   logic             r_rpt_run;
   logic             w_rpt_fire;

   assign w_rpt_fire = (r_rpt_cnt == (r_rpt_run ? LP_PERIOD_LAST : LP_DELAY_LAST));
`endif

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_s1 <= 1'b0;
         r_s2 <= 1'b0;
      end else begin
         r_s1 <= btn_in;
         r_s2 <= r_s1;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state   <= IDLE;
         r_cnt     <= '0;
         r_t       <= 1'b0;
         r_level   <= 1'b0;
`ifdef AUTO_REPEAT_EN
         r_rpt_cnt <= '0;
         r_rpt_run <= 1'b0;
`endif
      end else begin
         r_t <= 1'b0;
         case (r_state)
            IDLE: begin
               if (r_s2) begin
                  r_state <= ARM_PRESS;
                  r_cnt   <= LP_ONE;
               end
            end
            ARM_PRESS: begin
               if (!r_s2) begin
                  r_state <= IDLE;
                  r_cnt   <= '0;
               end else if (r_cnt == LP_DB_LAST) begin
                  r_state <= HELD;
                  r_cnt   <= '0;
                  r_t     <= 1'b1;
                  r_level <= 1'b1;
               end else begin
                  r_cnt <= r_cnt + LP_ONE;
               end
            end
            HELD: begin
               if (!r_s2) begin
                  r_state <= ARM_RELEASE;
                  r_cnt   <= LP_ONE;
`ifdef AUTO_REPEAT_EN
                  r_rpt_cnt <= '0;
                  r_rpt_run <= 1'b0;
               end else if (w_rpt_fire) begin
                  r_t       <= 1'b1;
                  r_rpt_cnt <= '0;
                  r_rpt_run <= 1'b1;
               end else begin
                  r_rpt_cnt <= r_rpt_cnt + LP_ONE;
`endif
               end
            end
            ARM_RELEASE: begin
               if (r_s2) begin
                  r_state <= HELD;
                  r_cnt   <= '0;
               end else if (r_cnt == LP_DB_LAST) begin
                  r_state <= IDLE;
                  r_cnt   <= '0;
                  r_level <= 1'b0;
               end else begin
                  r_cnt <= r_cnt + LP_ONE;
               end
            end
            default: begin
               r_state <= IDLE;
               r_cnt   <= '0;
            end
         endcase
`ifdef AUTO_REPEAT_EN
         // Outside HELD the repeat timer is parked so re-entry always waits the full delay
         if (r_state != HELD) begin
            r_rpt_cnt <= '0;
            r_rpt_run <= 1'b0;
         end
`endif
      end
   end

   assign t     = r_t;
   assign level = r_level;

endmodule
